mux_arb_nx1: RTL
================

# mux_arb_nx1

Parametrised N-input, WIDTH-bit selector with per-channel valid/ready handshakes and a registered output stage. Generalises the fixed 4:1 datapath mux to any channel count and width. Adds an optional round-robin mode so several producers, such as write-back sources or register-destination candidates, can share one consumer without losing data. Sits between producer stages and a single downstream pipeline register.

## Interface
- `WIDTH`, 5, data bits per channel
- `N`, 4, number of input channels (≥2; need not be a power of two)
- `SEL_W`, derived `$clog2(N)`, select/channel-index width (localparam, not overridable)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready (combinational)
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  SEL_W  channel index used in fixed mode
- `out_data`  out  WIDTH  registered selected word
- `out_chan`  out  SEL_W  index of the channel that supplied `out_data`
- `out_valid`  out  1  output holds a word
- `out_ready`  in  1  consumer accepts the word

## Operation
- Single-entry output register. `load = (!out_valid || out_ready) && |grant`.
- Fixed mode: `grant` is one-hot on `sel` if `sel < N && in_valid[sel]`, else 0. If `sel ≥ N`, nothing is granted and nothing is ever loaded.
- Round-robin mode: `grant` is the first valid channel at or after `ptr`, wrapping from N-1 to 0. `ptr` is SEL_W bits.
- On `load` in round-robin mode, `ptr` becomes (granted index + 1) mod N. `ptr` does not change in fixed mode.
- `in_ready[i] = grant[i] && (!out_valid || out_ready)`. At most one bit is set per cycle.
- On `load`: `out_data` ← granted word, `out_chan` ← granted index, `out_valid` ← 1.
- When `out_ready && out_valid && !load`, `out_valid` ← 0. `out_data` and `out_chan` hold their last values.
- Simultaneous drain and load: a new word replaces the old one in the same edge, giving full throughput of one word per cycle.
- A `mode` or `sel` change takes effect on arbitration in the same cycle. A word already held is unaffected, and `ptr` is retained across mode changes.
- Producers must hold `in_data`/`in_valid` stable until their `in_ready`. The block does not check this.

## Timing
- Latency: input-to-`out_valid` is 1 cycle.
- `in_ready` is combinational from `in_valid`, `sel`, `mode`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0. During reset `in_ready`=0.
- Reset asserted mid-transfer discards the held word. The first grant after reset is made on the first edge with `rst` low.

## Configuration
- `MUX_ARB_RR_EN` defined: round-robin mode, the `ptr` register and the picker are built, and `mode` behaves as specified.
- Not defined: the `mode` port is present but ignored and the block is fixed-select only. No `ptr` flop and no picker logic are generated.

## Structure
- Package `mux_pkg` holds:
  - default `WIDTH`/`N` constants;
  - a `mux_mode_e` enum (`MUX_FIXED`=0, `MUX_RR`=1);
  - a function mapping an index to a one-hot vector.
- Sub-module `mux_rr_pick`: combinational rotating-priority picker with inputs `req[N]` and `ptr`, and outputs one-hot `gnt[N]`, `gnt_idx` and `any`. It is instantiated only under `MUX_ARB_RR_EN`.

## Test plan
- **Reset:** reset values; fixed flow. Hold `rst`=1 with all `in_valid`=1 → `out_valid`=0, `in_ready`=0, `out_data`=0. Release, fixed mode, `sel`=2, `in_data` ch2=5'h15 → next cycle `out_data`=5'h15, `out_chan`=2.
- **Fixed-mode backpressure:** `out_ready`=0 after first load, ch2 presents 5'h0A → `in_ready[2]`=0 and `out_data` stays 5'h15 until `out_ready`=1. Then 5'h0A loads in the same edge that drains 5'h15.
- **Round-robin fairness:** N=4, all valid, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0 on consecutive cycles.
- **Round-robin skip and wrap:** only ch3 and ch1 valid, `ptr`=2 → grant 3, then 1, then 3.
- **Out-of-range select:** N=3, fixed mode, `sel`=3 → no `in_ready` and `out_valid` stays 0 for 10 cycles.
- **Mid-transfer reset:** assert `rst` with `out_valid`=1 → `out_valid`=0 asynchronously and `ptr`=0. After release, round-robin restarts at ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants, mode encoding and index helper for the N:1 arbitrated mux.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package mux_pkg;

   localparam int MUX_WIDTH_DEF = 5;
   localparam int MUX_N_DEF     = 4;
   // Widest channel count the one-hot helper can describe.
   localparam int MUX_N_MAX     = 64;

   typedef enum logic {
      MUX_FIXED = 1'b0,
      MUX_RR    = 1'b1
   } mux_mode_e;

   // Index to one-hot; callers size-cast the result down to their channel count.
   function automatic logic [MUX_N_MAX-1:0] idx_to_onehot(input int idx);
      logic [MUX_N_MAX-1:0] v;
      for (int i = 0; i < MUX_N_MAX; i++) begin
         v[i] = (i == idx);
      end
      return v;
   endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module mux_rr_pick
   import mux_pkg::*;
#(
   parameter  int N     = MUX_N_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any
);

   // Search ptr..N-1 first, then 0..ptr-1, so the lowest index at or after ptr wins.
   always_comb begin
      any     = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (i >= int'(ptr))) begin
            any     = 1'b1;
            gnt_idx = SEL_W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (i < int'(ptr))) begin
            any     = 1'b1;
            gnt_idx = SEL_W'(i);
         end
      end
      gnt = any ? N'(idx_to_onehot(int'(gnt_idx))) : '0;
   end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 valid/ready selector with one registered output slot; fixed select or round-robin (MUX_ARB_RR_EN).
// Latency: 1 cycle from accepted input to out_valid; one word per cycle when drain and load coincide.
// Backpressure: in_ready drops for every channel while the output slot is full and out_ready is low.
module mux_arb_nx1
   import mux_pkg::*;
#(
   parameter  int WIDTH = MUX_WIDTH_DEF,
   parameter  int N     = MUX_N_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [N-1:0]     fix_gnt;
   logic [SEL_W-1:0] fix_idx;
   logic             fix_any;

   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             any;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] word;

   // Fixed-select grant; a sel at or beyond N never matches a channel.
   always_comb begin
      fix_any = 1'b0;
      fix_idx = sel;
      for (int i = 0; i < N; i++) begin
         if ((int'(sel) == i) && in_valid[i]) begin
            fix_any = 1'b1;
         end
      end
      fix_gnt = fix_any ? N'(idx_to_onehot(int'(sel))) : '0;
   end

`ifdef MUX_ARB_RR_EN
   logic [SEL_W-1:0] ptr;
   logic [N-1:0]     rr_gnt;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_any;
   logic             use_rr;

   mux_rr_pick #(.N(N)) u_pick (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   assign use_rr = (mux_mode_e'(mode) == MUX_RR);

   // Mode chooses between the two arbiters in the same cycle it changes.
   always_comb begin
      gnt     = use_rr ? rr_gnt : fix_gnt;
      gnt_idx = use_rr ? rr_idx : fix_idx;
      any     = use_rr ? rr_any : fix_any;
   end

   // Pointer advances past the winner only on a round-robin load; kept across mode changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (load && use_rr) begin
         ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + SEL_W'(1);
      end
   end
`else
   // Without round-robin support the mode pin has no effect.
   logic unused_mode;
   assign unused_mode = mode;

   // Fixed select is the only arbitration source.
   always_comb begin
      gnt     = fix_gnt;
      gnt_idx = fix_idx;
      any     = fix_any;
   end
`endif

   // Slot can take a word when empty or draining this edge; nothing is accepted in reset.
   assign accept   = !rst && (!out_valid || out_ready);
   assign load     = accept && any;
   assign in_ready = gnt & {N{accept}};

   // AND-OR data select keyed on the one-hot grant.
   always_comb begin
      word = '0;
      for (int i = 0; i < N; i++) begin
         word = word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
      end
   end

   // Output slot: load overrides drain; data and channel hold after a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= word;
         out_chan  <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
